seq_mul: RTL and testbench

Parametrised sequential shift-and-add multiplier, the successor to the fixed 8-bit combinational array multiplier. It trades area for latency: one partial product is accumulated per clock. It adds a per-operation signed/unsigned mode and valid/ready handshakes on both input and output. It sits in the arithmetic datapath wherever a WIDTH x WIDTH product is needed and multi-cycle latency is acceptable.

---
 rtl/mul_pkg.sv | 16 +
 rtl/cond_neg.sv | 13 +
 rtl/seq_mul.sv | 154 +++++++++++++++
 tb/tb_seq_mul.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mul_pkg.sv
// Shared types and helpers for the sequential shift-and-add multiplier.
package mul_pkg;

    // Controller states; the spare encoding 2'b11 falls back to IDLE.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    // Iteration counter must hold values 0..width inclusive.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/cond_neg.sv
// Conditional two's-complement negation: y = en ? -x : x.
module cond_neg #(
    parameter int W = 8
) (
    input  logic [W-1:0] x,
    input  logic         en,
    output logic [W-1:0] y
);

    // Invert-and-increment only when negation is requested.
    assign y = en ? (~x + W'(1)) : x;

endmodule

// File: rtl/seq_mul.sv
// Sequential shift-and-add multiplier, one partial product per clock,
// with per-operation signed/unsigned mode and valid/ready on both sides.
//
//   state | meaning
//   ------+---------------------------------------------------------
//   IDLE  | waiting for operands, in_ready high
//   RUN   | accumulating one partial product per edge, WIDTH edges
//   DONE  | y/out_valid presented and held until out_ready
module seq_mul
    import mul_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 sgn,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   y,
    output logic                 busy
);

    localparam int            CW   = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     mcand_q, mcand_d;
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic [WIDTH-1:0]     lo_q, lo_d;
    logic                 neg_q, neg_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   y_q, y_d;
    logic                 out_valid_q, out_valid_d;

    logic [WIDTH-1:0]     mag_a, mag_b;
    logic [WIDTH:0]       sum;
    logic [WIDTH-1:0]     hi_nx, lo_nx;
    logic [2*WIDTH-1:0]   prod_nx, prod_signed;
    logic                 op_zero;

    // Operand magnitudes; negate only negative two's-complement inputs.
    cond_neg #(.W(WIDTH)) u_mag_a (
        .x  (a),
        .en (sgn & a[WIDTH-1]),
        .y  (mag_a)
    );

    cond_neg #(.W(WIDTH)) u_mag_b (
        .x  (b),
        .en (sgn & b[WIDTH-1]),
        .y  (mag_b)
    );

    // Apply the result sign to the product leaving the last iteration.
    cond_neg #(.W(2*WIDTH)) u_res (
        .x  (prod_nx),
        .en (neg_q),
        .y  (prod_signed)
    );

    assign op_zero = (a == '0) || (b == '0);

    // One shift-and-add step: add mcand into the high half, then shift right.
    always_comb begin
        sum     = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mcand_q} : '0);
        hi_nx   = sum[WIDTH:1];
        lo_nx   = {sum[0], lo_q[WIDTH-1:1]};
        prod_nx = {hi_nx, lo_nx};
    end

    // Next-state and datapath control.
    always_comb begin
        state_d     = state_q;
        mcand_d     = mcand_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        neg_d       = neg_q;
        cnt_d       = cnt_q;
        y_d         = y_q;
        out_valid_d = out_valid_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    mcand_d = mag_a;
                    lo_d    = mag_b;
                    hi_d    = '0;
                    cnt_d   = '0;
                    neg_d   = sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
                    if (op_zero) begin
                        y_d         = '0;
                        out_valid_d = 1'b1;
                        state_d     = DONE;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                hi_d  = hi_nx;
                lo_d  = lo_nx;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    y_d         = prod_signed;
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                state_d     = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset abandons any operation at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            mcand_q     <= '0;
            hi_q        <= '0;
            lo_q        <= '0;
            neg_q       <= 1'b0;
            cnt_q       <= '0;
            y_q         <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            mcand_q     <= mcand_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            neg_q       <= neg_d;
            cnt_q       <= cnt_d;
            y_q         <= y_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q == RUN) || (state_q == DONE);
    assign y         = y_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_seq_mul.sv
// Directed and randomised bench for seq_mul at WIDTH = 4, 8 and 16.
module tb_seq_mul;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic        sgn_drv = 1'b0;
    logic [15:0] a_drv = '0;
    logic [15:0] b_drv = '0;
    int          sel = 1;

    always #5 clk = ~clk;

    logic iv4, iv8, iv16;
    logic ir4, ir8, ir16, ov4, ov8, ov16, bz4, bz8, bz16;
    logic [7:0]  y4;
    logic [15:0] y8;
    logic [31:0] y16;

    assign iv4  = in_valid && (sel == 0);
    assign iv8  = in_valid && (sel == 1);
    assign iv16 = in_valid && (sel == 2);

    seq_mul #(.WIDTH(4)) u_w4 (
        .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(ir4),
        .a(a_drv[3:0]), .b(b_drv[3:0]), .sgn(sgn_drv),
        .out_valid(ov4), .out_ready(out_ready), .y(y4), .busy(bz4)
    );

    seq_mul #(.WIDTH(8)) u_w8 (
        .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8),
        .a(a_drv[7:0]), .b(b_drv[7:0]), .sgn(sgn_drv),
        .out_valid(ov8), .out_ready(out_ready), .y(y8), .busy(bz8)
    );

    seq_mul #(.WIDTH(16)) u_w16 (
        .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ir16),
        .a(a_drv), .b(b_drv), .sgn(sgn_drv),
        .out_valid(ov16), .out_ready(out_ready), .y(y16), .busy(bz16)
    );

    logic [31:0] y_m;
    logic        ov_m, ir_m, busy_m;

    always_comb begin
        y_m = '0; ov_m = 1'b0; ir_m = 1'b0; busy_m = 1'b0;
        case (sel)
            0: begin y_m = {24'd0, y4};  ov_m = ov4;  ir_m = ir4;  busy_m = bz4;  end
            1: begin y_m = {16'd0, y8};  ov_m = ov8;  ir_m = ir8;  busy_m = bz8;  end
            default: begin y_m = y16;    ov_m = ov16; ir_m = ir16; busy_m = bz16; end
        endcase
    end

    int          passed = 0;
    int          total = 0;
    logic [31:0] exp_q[$];

    function automatic int cur_w();
        return (sel == 0) ? 4 : (sel == 1) ? 8 : 16;
    endfunction

    // Reference product: sign-extend (when signed) and multiply in 64 bits.
    function automatic logic [31:0] ref_mul(input logic [15:0] a, input logic [15:0] b,
                                            input bit s, input int w);
        longint m, sa, sbv, p;
        m   = (longint'(1) << w) - 1;
        sa  = longint'({48'd0, a}) & m;
        sbv = longint'({48'd0, b}) & m;
        if (s && a[w-1]) sa  = sa  - (longint'(1) << w);
        if (s && b[w-1]) sbv = sbv - (longint'(1) << w);
        p = sa * sbv;
        if (w == 16) return p[31:0];
        return p[31:0] & ((32'd1 << (2 * w)) - 32'd1);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    endtask

    // Pops the scoreboard whenever a result is handed over on the next edge.
    task automatic monitor();
        logic [31:0] e;
        forever begin
            @(negedge clk);
            if (!rst && ov_m && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("sb_unexpected_out", 32'(exp_q.size()), 32'd1);
                end else begin
                    e = exp_q.pop_front();
                    chk("sb_y", y_m, e);
                end
            end
        end
    endtask

    task automatic accept(input logic [15:0] a, input logic [15:0] b, input bit s, input bit push);
        int g;
        g = 0;
        while (!ir_m && g < 300) begin
            @(posedge clk); #1;
            g++;
        end
        if (!ir_m) chk("accept_timeout", 32'(ir_m), 32'd1);
        a_drv = a; b_drv = b; sgn_drv = s; in_valid = 1'b1;
        if (push) exp_q.push_back(ref_mul(a, b, s, cur_w()));
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Counts edges after the accept edge until out_valid is seen.
    task automatic wait_valid(output int n, output bit saw_ready);
        n = 0;
        saw_ready = 1'b0;
        while (!ov_m && n < 100) begin
            if (ir_m) saw_ready = 1'b1;
            @(posedge clk); #1;
            n++;
        end
    endtask

    initial begin
        int          n;
        bit          sr;
        int          g;
        logic [15:0] ra, rb, msk;
        bit          rs;
        logic [15:0] t2_a [4] = '{16'h80, 16'h80, 16'hFF, 16'h80};
        logic [15:0] t2_b [4] = '{16'h80, 16'h7F, 16'h01, 16'h7F};
        bit          t2_s [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
        logic [31:0] t2_y [4] = '{32'h4000, 32'hC080, 32'hFFFF, 32'h3F80};

        fork
            monitor();
        join_none

        // Reset values
        #2;
        chk("rst_in_ready", 32'(ir_m), 32'd1);
        chk("rst_out_valid", 32'(ov_m), 32'd0);
        chk("rst_y", y_m, 32'd0);
        chk("rst_busy", 32'(busy_m), 32'd0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        out_ready = 1'b1;

        // Largest unsigned product, latency and single-cycle valid
        sel = 1;
        accept(16'hFF, 16'hFF, 1'b0, 1'b1);
        wait_valid(n, sr);
        chk("t1_latency", 32'(n), 32'd8);
        chk("t1_ready_low", 32'(sr), 32'd0);
        chk("t1_y", y_m, 32'hFE01);
        @(posedge clk); #1;
        chk("t1_valid_drop", 32'(ov_m), 32'd0);
        chk("t1_ready_back", 32'(ir_m), 32'd1);

        // Signed extremes and the same operands unsigned
        for (int i = 0; i < 4; i++) begin
            accept(t2_a[i], t2_b[i], t2_s[i], 1'b1);
            wait_valid(n, sr);
            chk("t2_latency", 32'(n), 32'd8);
            chk("t2_y", y_m, t2_y[i]);
            @(posedge clk); #1;
        end

        // Zero shortcut
        accept(16'h00, 16'h5A, 1'b0, 1'b1);
        wait_valid(n, sr);
        chk("t3_zero_latency", 32'(n), 32'd0);
        chk("t3_zero_y", y_m, 32'd0);
        @(posedge clk); #1;
        accept(16'hFF, 16'h00, 1'b1, 1'b1);
        wait_valid(n, sr);
        chk("t3_zero_latency_s", 32'(n), 32'd0);
        chk("t3_zero_y_s", y_m, 32'd0);
        @(posedge clk); #1;

        // Backpressure with a held new request
        out_ready = 1'b0;
        accept(16'h12, 16'h34, 1'b0, 1'b1);
        wait_valid(n, sr);
        chk("t4_latency", 32'(n), 32'd8);
        a_drv = 16'h05; b_drv = 16'h06; sgn_drv = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("t4_y_hold", y_m, 32'h03A8);
            chk("t4_valid_hold", 32'(ov_m), 32'd1);
            chk("t4_ready_low", 32'(ir_m), 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("t4_valid_drop", 32'(ov_m), 32'd0);
        chk("t4_ready_back", 32'(ir_m), 32'd1);
        exp_q.push_back(ref_mul(16'h05, 16'h06, 1'b0, 8));
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("t4_held_accepted", 32'(busy_m), 32'd1);
        wait_valid(n, sr);
        chk("t4_held_latency", 32'(n), 32'd8);
        chk("t4_held_y", y_m, 32'h001E);
        @(posedge clk); #1;

        // Asynchronous reset in the middle of RUN
        accept(16'hAB, 16'hCD, 1'b0, 1'b0);
        @(posedge clk); @(posedge clk); @(posedge clk); #2;
        chk("t5_busy_before", 32'(busy_m), 32'd1);
        rst = 1'b1;
        #1;
        chk("t5_rst_out_valid", 32'(ov_m), 32'd0);
        chk("t5_rst_y", y_m, 32'd0);
        chk("t5_rst_busy", 32'(busy_m), 32'd0);
        chk("t5_rst_in_ready", 32'(ir_m), 32'd1);
        @(posedge clk); #1;
        rst = 1'b0;
        accept(16'd13, 16'd11, 1'b0, 1'b1);
        wait_valid(n, sr);
        chk("t5_latency", 32'(n), 32'd8);
        chk("t5_y", y_m, 32'h008F);
        @(posedge clk); #1;

        // WIDTH=4 signed
        sel = 0;
        accept(16'h7, 16'h8, 1'b1, 1'b1);
        wait_valid(n, sr);
        chk("t6_latency", 32'(n), 32'd4);
        chk("t6_y", y_m, 32'h00C8);
        @(posedge clk); #1;

        // Randomised operations with random gaps and backpressure
        for (int s = 0; s < 3; s++) begin
            sel = s;
            msk = (cur_w() == 16) ? 16'hFFFF : 16'((32'd1 << cur_w()) - 32'd1);
            for (int i = 0; i < 334; i++) begin
                repeat ($urandom_range(0, 3)) begin
                    @(posedge clk); #1;
                end
                ra = 16'($urandom()) & msk;
                rb = 16'($urandom()) & msk;
                case ($urandom_range(0, 9))
                    0: ra = '0;
                    1: rb = '0;
                    2: ra = msk;
                    3: rb = (msk >> 1) + 16'd1;
                    default: ;
                endcase
                rs = 1'($urandom_range(0, 1));
                accept(ra, rb, rs, 1'b1);
                g = 0;
                while (exp_q.size() != 0 && g < 300) begin
                    out_ready = 1'($urandom_range(0, 1));
                    @(posedge clk); #1;
                    g++;
                end
                if (exp_q.size() != 0) begin
                    chk("rand_drain_timeout", 32'(exp_q.size()), 32'd0);
                    exp_q.delete();
                end
                out_ready = 1'b1;
            end
        end

        chk("sb_empty_end", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
